fp_add_normalize: RTL and testbench



---
 rtl/fp_add_normalize.sv | 169 ++++++++++++++++
 tb/tb_fp_add_normalize.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_normalize.sv
// rtl/fp_add_normalize.sv - FP adder normalize/round/pack, 3-stage pipeline; FP_ADD_ROUND_EN selects round-to-nearest-even (else truncate)
module fp_add_normalize #(
  parameter bit FLUSH_SIGN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [31:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_inexact
);

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Stage 1: detect headroom carry or count leading zeros
  logic [30:0]       d1_mant;
  logic signed [9:0] d1_exp;
  logic [4:0]        d1_lzc;
  logic              d1_zero;

  always_comb begin
    d1_mant = in_mant[30:0];
    d1_exp  = {2'b00, in_exp};
    d1_lzc  = 5'd0;
    d1_zero = (in_mant == 32'd0);
    if (in_mant[31]) begin
      d1_mant = {in_mant[31:2], in_mant[1] | in_mant[0]};
      d1_exp  = $signed({2'b00, in_exp}) + 10'sd1;
    end else begin
      for (int i = 0; i < 31; i++) begin
        if (in_mant[i]) d1_lzc = 5'(30 - i);
      end
    end
  end

  logic              s1_valid;
  logic              s1_sign;
  logic [30:0]       s1_mant;
  logic signed [9:0] s1_exp;
  logic [4:0]        s1_lzc;
  logic              s1_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mant  <= '0;
      s1_exp   <= '0;
      s1_lzc   <= '0;
      s1_zero  <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= in_sign;
      s1_mant  <= d1_mant;
      s1_exp   <= d1_exp;
      s1_lzc   <= d1_lzc;
      s1_zero  <= d1_zero;
    end
  end

  // Stage 2: left shift and exponent adjust
  logic [30:0]       d2_mant;
  logic signed [9:0] d2_exp;
  logic              d2_unf;

  always_comb begin
    d2_mant = s1_mant << s1_lzc;
    d2_exp  = s1_exp - $signed({5'b00000, s1_lzc});
    d2_unf  = ~s1_zero & (d2_exp <= 10'sd0);
  end

  logic              s2_valid;
  logic              s2_sign;
  logic [30:0]       s2_mant;
  logic signed [9:0] s2_exp;
  logic              s2_unf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_mant  <= '0;
      s2_exp   <= '0;
      s2_unf   <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_mant  <= d2_mant;
      s2_exp   <= d2_exp;
      s2_unf   <= d2_unf;
    end
  end

  // Stage 3: round and pack. A normalized nonzero value always has bit30 set,
  // so a clear bit30 here means exact cancellation.
  logic              s3_zero;
  logic              s3_lsb;
  logic              s3_g;
  logic              s3_r;
  logic              s3_s;
  logic              round_up;
  logic [23:0]       frac_sum;
  logic signed [9:0] d3_exp;
  logic              d3_ovf;
  logic [31:0]       d3_result;
  logic              d3_ovf_flag;
  logic              d3_unf_flag;
  logic              d3_inexact;

  always_comb begin
    s3_zero = ~s2_mant[30];
    s3_lsb  = s2_mant[7];
    s3_g    = s2_mant[6];
    s3_r    = s2_mant[5];
    s3_s    = |s2_mant[4:0];
`ifdef FP_ADD_ROUND_EN
    round_up = s3_g & (s3_r | s3_s | s3_lsb);
`else
    round_up = 1'b0;
`endif
    // All-ones fraction plus one wraps to zero with the carry in bit 23
    frac_sum = {1'b0, s2_mant[29:7]} + {23'd0, round_up};
    d3_exp   = frac_sum[23] ? s2_exp + 10'sd1 : s2_exp;
    d3_ovf   = (d3_exp >= 10'sd255);

    d3_result   = {s2_sign, d3_exp[7:0], frac_sum[22:0]};
    d3_ovf_flag = 1'b0;
    d3_unf_flag = 1'b0;
    d3_inexact  = s3_g | s3_r | s3_s;
    if (s3_zero) begin
      d3_result  = 32'd0;
      d3_inexact = 1'b0;
    end else if (s2_unf) begin
      d3_result   = {FLUSH_SIGN ? s2_sign : 1'b0, 31'd0};
      d3_unf_flag = 1'b1;
      d3_inexact  = 1'b1;
    end else if (d3_ovf) begin
      d3_result   = {s2_sign, 8'hFF, 23'd0};
      d3_ovf_flag = 1'b1;
      d3_inexact  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_result    <= 32'd0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (adv) begin
      out_valid     <= s2_valid;
      out_result    <= s2_valid ? d3_result : 32'd0;
      out_overflow  <= s2_valid & d3_ovf_flag;
      out_underflow <= s2_valid & d3_unf_flag;
      out_inexact   <= s2_valid & d3_inexact;
    end
  end

endmodule

// File: tb/tb_fp_add_normalize.sv
// tb/tb_fp_add_normalize.sv - self-checking bench for fp_add_normalize with a value-level reference model
module tb_fp_add_normalize;

  localparam bit FLUSH_SIGN = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [31:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  always #5 clk = ~clk;

  fp_add_normalize #(.FLUSH_SIGN(FLUSH_SIGN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow),
    .out_underflow(out_underflow), .out_inexact(out_inexact)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  logic [34:0] q[$];
  logic        held_v;
  logic [34:0] held;

  wire [34:0] dut_bus = {out_overflow, out_underflow, out_inexact, out_result};

  function automatic void chk(input string name, input logic [34:0] act, input logic [34:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endfunction

  // Exact value model: locate the top set bit, keep 24 significant bits, round the rest.
  function automatic logic [34:0] model(input logic s, input logic [7:0] e, input logic [31:0] m);
    int p;
    int ee;
    longint mm;
    longint sig;
    longint rem;
    longint half;
    logic up;
    logic [7:0] e8;
    logic [22:0] f23;
    if (m == 32'd0) return 35'd0;
    p = -1;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    ee = int'(e) + p - 30;
    if (ee <= 0) return {3'b011, FLUSH_SIGN ? s : 1'b0, 31'd0};
    mm = {32'd0, m};
    if (p > 23) begin
      sig  = mm >> (p - 23);
      rem  = mm & ((64'd1 << (p - 23)) - 1);
      half = 64'd1 << (p - 24);
    end else begin
      sig  = mm << (23 - p);
      rem  = 0;
      half = 1;
    end
`ifdef FP_ADD_ROUND_EN
    up = (rem > half) || (rem == half && (sig & 1) == 1);
`else
    up = 1'b0;
`endif
    if (up) sig = sig + 1;
    if (sig == (64'd1 << 24)) begin
      sig = 64'd1 << 23;
      ee  = ee + 1;
    end
    if (ee >= 255) return {3'b101, s, 8'hFF, 23'd0};
    e8  = ee[7:0];
    f23 = sig[22:0];
    return {2'b00, rem != 0, s, e8, f23};
  endfunction

  // Per-cycle checker: handshake rule, hold stability, in-order results vs model
  initial begin
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        held_v = 1'b0;
      end else begin
        chk("in_ready", {34'd0, in_ready}, {34'd0, !out_valid || out_ready});
        if (held_v && out_valid) chk("hold stable", dut_bus, held);
        held_v = out_valid && !out_ready;
        held   = dut_bus;
        if (out_valid && out_ready) begin
          n_out++;
          if (q.size() == 0) chk("unexpected output", {34'd0, out_valid}, 35'd0);
          else chk("stream result", dut_bus, q.pop_front());
        end
        if (in_valid && in_ready) q.push_back(model(in_sign, in_exp, in_mant));
      end
    end
  end

  task automatic drive_beat(input logic s, input logic [7:0] e, input logic [31:0] m);
    int b;
    logic acc;
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    b   = 0;
    acc = 1'b0;
    while (!acc && b < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      b++;
    end
    #1;
    in_valid = 1'b0;
    if (!acc) chk("accept timeout", 35'd0, 35'd1);
  endtask

  task automatic directed(input string name, input logic s, input logic [7:0] e,
                          input logic [31:0] m, input logic [34:0] expv);
    int k;
    drive_beat(s, e, m);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 20);
    chk({name, " latency"}, 35'(k), 35'd3);
    chk(name, dut_bus, expv);
    chk({name, " model"}, model(s, e, m), expv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int base;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'd0;
    in_mant   = 32'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", {34'd0, out_valid}, 35'd0);
    chk("reset outputs", dut_bus, 35'd0);
    chk("reset in_ready", {34'd0, in_ready}, 35'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("one+one",      1'b0, 8'd127, 32'h80000000, {3'b000, 32'h40000000});
    directed("cancel lzc23", 1'b0, 8'd127, 32'h00000080, {3'b000, 32'h34000000});
    directed("lzc7",         1'b0, 8'd127, 32'h00800000, {3'b000, 32'h3C000000});
`ifdef FP_ADD_ROUND_EN
    directed("round odd",    1'b0, 8'd127, 32'h400000C0, {3'b001, 32'h3F800002});
    directed("round carry",  1'b0, 8'd127, 32'h7FFFFFC0, {3'b001, 32'h40000000});
    directed("round ovf",    1'b0, 8'd254, 32'h7FFFFFC0, {3'b101, 32'h7F800000});
    directed("rshift tie",   1'b0, 8'd127, 32'h80000180, {3'b001, 32'h40000002});
`else
    directed("round odd",    1'b0, 8'd127, 32'h400000C0, {3'b001, 32'h3F800001});
    directed("round carry",  1'b0, 8'd127, 32'h7FFFFFC0, {3'b001, 32'h3FFFFFFF});
    directed("round ovf",    1'b0, 8'd254, 32'h7FFFFFC0, {3'b001, 32'h7F7FFFFF});
    directed("rshift tie",   1'b0, 8'd127, 32'h80000180, {3'b001, 32'h40000001});
`endif
    directed("tie even",     1'b0, 8'd127, 32'h40000040, {3'b001, 32'h3F800000});
    directed("rshift sticky",1'b0, 8'd127, 32'h80000101, {3'b001, 32'h40000001});
    directed("overflow",     1'b0, 8'd254, 32'h80000000, {3'b101, 32'h7F800000});
    directed("neg overflow", 1'b1, 8'd254, 32'h80000000, {3'b101, 32'hFF800000});
    directed("underflow",    1'b0, 8'd3,   32'h00000100, {3'b011, 32'h00000000});
    directed("neg underflow",1'b1, 8'd3,   32'h00000100, {3'b011, 32'h00000000});
    directed("exp_i zero",   1'b0, 8'd1,   32'h20000000, {3'b011, 32'h00000000});
    directed("min normal",   1'b0, 8'd1,   32'h40000000, {3'b000, 32'h00800000});
    directed("exact zero",   1'b1, 8'd200, 32'h00000000, {3'b000, 32'h00000000});
    directed("neg one",      1'b1, 8'd127, 32'h40000000, {3'b000, 32'hBF800000});

    // Five-beat stream with a four-cycle output stall after the first result
    base = n_out;
    fork
      begin
        for (int i = 0; i < 5; i++)
          drive_beat(i[0], 8'(100 + 7 * i), 32'h40000000 + 32'(i * 32'h01234567));
      end
      begin
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!out_valid && k < 50);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    chk("stream count", 35'(n_out - base), 35'd5);
    chk("stream drained", 35'(q.size()), 35'd0);

    // Reset with three beats in flight, one already presented at the output
    drive_beat(1'b0, 8'd127, 32'h80000000);
    drive_beat(1'b0, 8'd130, 32'h40000000);
    drive_beat(1'b1, 8'd90,  32'h00010000);
    chk("pre-reset out_valid", {34'd0, out_valid}, 35'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", {34'd0, out_valid}, 35'd0);
    chk("async reset outputs", dut_bus, 35'd0);
    chk("async reset in_ready", {34'd0, in_ready}, 35'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    directed("after reset", 1'b0, 8'd128, 32'h40000000, {3'b000, 32'h40000000});
    repeat (4) @(posedge clk);
    #1;
    chk("final drained", 35'(q.size()), 35'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
